// File: rtl/adc_seq_ctrl.sv
// SAR ADC sequencer: launch conversion, wait for synchronised finish, load and shift result out while shifting config in.
// Result held under valid/ready; HOLD blocks further conversions until accepted.
module adc_seq_ctrl #(
  parameter int RES_BITS    = 12,
  parameter int TIMEOUT_CYC = 1023,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                cont,
  input  logic [RES_BITS-1:0] cfg_word,
  output logic [RES_BITS-1:0] result,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                busy,
  output logic                timeout,
  output logic                adc_conv_start,
  input  logic                adc_conv_finish,
  output logic                adc_load,
  output logic                adc_dati,
  input  logic                adc_dato
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam int BIT_W = $clog2(RES_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_LOAD,
    S_SHIFT,
    S_HOLD
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic [BIT_W-1:0]       r_bit;
  logic [RES_BITS-1:0]    r_tx;
  logic [RES_BITS-1:0]    r_rx;
  logic [RES_BITS-1:0]    r_result;
  logic                   r_timeout;
  logic                   w_fin_s;
  logic                   w_cnt_max;
  logic                   w_bit_last;
  logic [RES_BITS-1:0]    w_rx_next;

  assign w_fin_s    = r_sync[SYNC_STAGES-1];
  assign w_cnt_max  = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign w_bit_last = (r_bit == BIT_W'(RES_BITS - 1));
  assign w_rx_next  = {r_rx[RES_BITS-2:0], adc_dato};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sync  <= '0;
    end else begin
      r_state <= w_next;
      r_sync  <= {r_sync[SYNC_STAGES-2:0], adc_conv_finish};
    end
  end

  always_comb begin
    w_next         = r_state;
    adc_conv_start = 1'b0;
    adc_load       = 1'b0;
    adc_dati       = 1'b0;
    result_valid   = 1'b0;
    busy           = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: if (start) w_next = S_CONV;
      S_CONV: begin
        adc_conv_start = 1'b1;
        // A finish seen on the last allowed cycle still wins over the timeout
        if (w_fin_s)        w_next = S_LOAD;
        else if (w_cnt_max) w_next = S_IDLE;
      end
      S_LOAD: begin
        adc_load = 1'b1;
        w_next   = S_SHIFT;
      end
      S_SHIFT: begin
        adc_dati = r_tx[RES_BITS-1];
        if (w_bit_last) w_next = S_HOLD;
      end
      S_HOLD: begin
        result_valid = 1'b1;
        if (result_ready) w_next = cont ? S_CONV : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_bit     <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_result  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt <= (r_state == S_CONV && w_next == S_CONV) ? r_cnt + 1'b1 : '0;
      if (r_state == S_IDLE && start)
        r_timeout <= 1'b0;
      else if (r_state == S_CONV && !w_fin_s && w_cnt_max)
        r_timeout <= 1'b1;
      if (r_state == S_LOAD) begin
        r_tx  <= cfg_word;
        r_bit <= '0;
      end
      if (r_state == S_SHIFT) begin
        r_tx  <= {r_tx[RES_BITS-2:0], 1'b0};
        r_rx  <= w_rx_next;
        r_bit <= r_bit + 1'b1;
        if (w_bit_last) r_result <= w_rx_next;
      end
    end
  end

  assign result  = r_result;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Bench for adc_seq_ctrl: behavioural SAR ADC on the falling edge, scoreboard of expected codes checked at each handshake.
module tb_adc_seq_ctrl;

  localparam int RB = 12;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          cont;
  logic [RB-1:0] cfg_word;
  logic [RB-1:0] result;
  logic          result_valid;
  logic          result_ready;
  logic          busy;
  logic          timeout;
  logic          adc_conv_start;
  logic          adc_conv_finish = 1'b0;
  logic          adc_load;
  logic          adc_dati;
  logic          adc_dato = 1'b0;

  always #5 clk = ~clk;

  adc_seq_ctrl #(.RES_BITS(RB), .TIMEOUT_CYC(1023), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .cfg_word(cfg_word),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .busy(busy), .timeout(timeout), .adc_conv_start(adc_conv_start),
    .adc_conv_finish(adc_conv_finish), .adc_load(adc_load),
    .adc_dati(adc_dati), .adc_dato(adc_dato)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ADC model and monitors
  logic [RB-1:0] code_q[$];
  logic [RB-1:0] exp_q[$];
  int            fin_delay = 0;
  int            cs_cnt    = 0;
  bit            fin_stale = 0;
  logic [RB-1:0] adc_sreg  = '0;
  logic [RB-1:0] cfg_cap   = '0;
  int            shift_cnt = 0;
  int            n_load    = 0;
  int            n_cs_rise = 0;
  int            n_cs_hi   = 0;
  int            n_hs      = 0;
  bit            cs_prev   = 0;

  always @(negedge clk) begin
    if (adc_conv_start) begin
      if (cs_cnt == 0) fin_stale = adc_conv_finish;
      if (cs_cnt == SS && fin_stale)
        assert (!adc_conv_finish) else $error("stale conv_finish held too long");
      if (fin_delay > 0 && cs_cnt == fin_delay) adc_conv_finish = 1'b1;
      cs_cnt++;
      n_cs_hi++;
      if (!cs_prev) n_cs_rise++;
    end else begin
      cs_cnt          = 0;
      adc_conv_finish = 1'b0;
    end
    cs_prev = adc_conv_start;

    if (adc_load) begin
      n_load++;
      adc_sreg  = (code_q.size() > 0) ? code_q.pop_front() : '0;
      cfg_cap   = '0;
      shift_cnt = RB;
    end else if (shift_cnt > 0) begin
      cfg_cap  = {cfg_cap[RB-2:0], adc_dati};
      adc_dato = adc_sreg[shift_cnt-1];
      shift_cnt--;
    end

    if (result_valid && result_ready) begin
      n_hs++;
      if (exp_q.size() == 0) check("sb_unexpected_result", 32'(result), 32'hFFFF_FFFF);
      else check("sb_result", 32'(result), 32'(exp_q.pop_front()));
    end
  end

  // Call at posedge+#1; returns cycles from the start-sampling edge to result_valid
  task automatic run_shot(input logic [RB-1:0] code, input logic [RB-1:0] exp,
                          input logic [RB-1:0] cfg, input int fin, output int lat);
    fin_delay = fin;
    cfg_word  = cfg;
    code_q.push_back(code);
    exp_q.push_back(exp);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    while (!result_valid && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while (busy && c < 2000) begin
      @(posedge clk); #1;
      c++;
    end
    check(name, 32'(busy), 0);
  endtask

  typedef struct {
    logic [RB-1:0] code;
    logic [RB-1:0] cfg;
    int            fin;
    logic [RB-1:0] exp_res;
    int            exp_lat;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int lat, cyc, hs, bp_bad, exp_hs;
    bit hs_pend;

    vecs[0] = '{code: 12'hA5C, cfg: 12'h3F1, fin: 20, exp_res: 12'hA5C, exp_lat: 36};
    vecs[1] = '{code: 12'h000, cfg: 12'hFFF, fin: 5,  exp_res: 12'h000, exp_lat: 21};
    vecs[2] = '{code: 12'hFFF, cfg: 12'h000, fin: 1,  exp_res: 12'hFFF, exp_lat: 17};
    exp_hs = 0;

    rst_n = 1'b0; start = 1'b0; cont = 1'b0; cfg_word = '0; result_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({result, result_valid, busy, timeout, adc_conv_start, adc_load, adc_dati}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) begin
      n_load = 0;
      run_shot(vecs[i].code, vecs[i].exp_res, vecs[i].cfg, vecs[i].fin, lat);
      exp_hs++;
      check("latency", 32'(lat), 32'(vecs[i].exp_lat));
      @(posedge clk); #1;
      check("busy_after_accept", 32'(busy), 0);
      check("dati_stream", 32'(cfg_cap), 32'(vecs[i].cfg));
      check("load_pulses", 32'(n_load), 1);
    end

    // Backpressure
    result_ready = 1'b0;
    n_cs_rise = 0;
    run_shot(12'hA5C, 12'hA5C, 12'h3F1, 20, lat);
    exp_hs++;
    check("bp_latency", 32'(lat), 36);
    bp_bad = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (!(result_valid && result === 12'hA5C && busy && !adc_conv_start)) bp_bad++;
    end
    check("bp_hold_cycles_bad", 32'(bp_bad), 0);
    check("bp_conv_starts", 32'(n_cs_rise), 1);
    result_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_busy_after", 32'(busy), 0);
    check("bp_valid_after", 32'(result_valid), 0);

    // Continuous mode
    cont = 1'b1; fin_delay = 10; cfg_word = 12'h155;
    code_q.push_back(12'h001); exp_q.push_back(12'h001);
    code_q.push_back(12'hFFF); exp_q.push_back(12'hFFF);
    code_q.push_back(12'h800); exp_q.push_back(12'h800);
    exp_hs += 3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hs = 0; hs_pend = 0; cyc = 0;
    while ((hs < 3 || hs_pend) && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
      if (hs_pend) begin
        if (hs < 3) check("cont_restart", 32'(adc_conv_start), 1);
        else        check("cont_end_idle", 32'(busy), 0);
        if (hs == 2) cont = 1'b0;
      end
      hs_pend = result_valid && result_ready;
      if (hs_pend) hs++;
    end
    check("cont_handshakes", 32'(hs), 3);

    // Timeout
    fin_delay = 0; n_cs_hi = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 1100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("to_conv_start_cycles", 32'(n_cs_hi), 1023);
    check("to_flag", 32'(timeout), 1);
    check("to_idle", 32'(busy), 0);
    check("to_valid", 32'(result_valid), 0);
    check("to_result_kept", 32'(result), 32'h800);
    start = 1'b1;
    @(posedge clk); #1;
    check("to_cleared_on_start", 32'(timeout), 0);
    start = 1'b0;
    wait_idle("to_abort_idle");
    run_shot(12'h3C3, 12'h3C3, 12'h0AA, 20, lat);
    exp_hs++;
    check("to_next_latency", 32'(lat), 36);
    @(posedge clk); #1;

    // Reset in SHIFT cycle 5
    fin_delay = 3; cfg_word = 12'h0F0;
    code_q.push_back(12'h5A5); exp_q.push_back(12'h5A5);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!adc_load && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rst_reached_load", 32'(adc_load), 1);
    repeat (6) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", 32'({result, result_valid, busy, timeout, adc_conv_start, adc_load, adc_dati}), 0);
    exp_q.delete();
    code_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_shot(12'h6B2, 12'h6B2, 12'h3F1, 20, lat);
    exp_hs++;
    check("rst_clean_latency", 32'(lat), 36);
    @(posedge clk); #1;

    // Start pulses while busy are dropped
    n_cs_rise = 0; n_load = 0; fin_delay = 20;
    code_q.push_back(12'h2D7); exp_q.push_back(12'h2D7);
    exp_hs++;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!adc_load && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (4) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle("ign_idle");
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("ign_conv_starts", 32'(n_cs_rise), 1);
    check("ign_loads", 32'(n_load), 1);
    check("ign_still_idle", 32'(busy), 0);

    check("sb_empty", 32'(exp_q.size()), 0);
    check("handshake_total", 32'(n_hs), 32'(exp_hs));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
